commit_monitor: RTL and testbench

Consumer end of the CPU core's retirement interface (commit, commit_instr, commit_pc, commit_pre_pc), instantiated beside top_cpu in simulation and FPGA debug builds. It checks PC-flow continuity between consecutive commits and counts retired instructions and cycles. It detects ebreak halt and no-progress timeouts. Each commit record is buffered in a FIFO, which a ready/valid reader (testbench or debug UART bridge) drains.

---
 rtl/commit_monitor.sv | 118 +++++++++++
 tb/tb_commit_monitor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/commit_monitor.sv
// Retirement-side monitor: checks PC continuity, counts retired instructions and run cycles,
// detects ebreak halt and commit timeouts, and buffers commit records in a ready/valid trace FIFO.
module commit_monitor #(
    parameter int          FIFO_DEPTH     = 16,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [63:0] RESET_PC       = 64'h8000_0000,
    parameter logic [31:0] EBREAK_INSTR   = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit,
    input  logic [31:0] commit_instr,
    input  logic [63:0] commit_pc,
    input  logic [63:0] commit_pre_pc,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [63:0] trace_pc,
    output logic [31:0] trace_instr,
    output logic [63:0] instr_cnt,
    output logic [63:0] cycle_cnt,
    output logic        running,
    output logic        halted,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [63:0] err_pc,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_ERROR} state_t;

    state_t        r_state;
    logic [63:0]   r_expected_pc;
    logic [63:0]   r_instr_cnt;
    logic [63:0]   r_cycle_cnt;
    logic [1:0]    r_err_code;
    logic [63:0]   r_err_pc;
    logic          r_overflow;
    logic [TW-1:0] r_timer;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [63:0]   r_mem_pc    [FIFO_DEPTH];
    logic [31:0]   r_mem_instr [FIFO_DEPTH];

    logic w_live, w_accept, w_empty, w_full, w_pop, w_push, w_drop, w_active;

    assign w_live   = (r_state == S_IDLE) || (r_state == S_RUN);
    assign w_accept = w_live && commit && (commit_pc == r_expected_pc);
    // The IDLE->RUN edge is the first counted cycle.
    assign w_active = (r_state == S_RUN) || ((r_state == S_IDLE) && commit);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && trace_ready;
    assign w_push  = w_accept && (!w_full || w_pop);
    assign w_drop  = w_accept && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr[AW-1:0]]    <= commit_pc;
            r_mem_instr[r_wr_ptr[AW-1:0]] <= commit_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_expected_pc <= RESET_PC;
            r_instr_cnt   <= '0;
            r_cycle_cnt   <= '0;
            r_err_code    <= '0;
            r_err_pc      <= '0;
            r_overflow    <= 1'b0;
            r_timer       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if (w_pop)    r_rd_ptr    <= r_rd_ptr + 1'b1;
            if (w_push)   r_wr_ptr    <= r_wr_ptr + 1'b1;
            if (w_drop)   r_overflow  <= 1'b1;
            if (w_active) r_cycle_cnt <= r_cycle_cnt + 64'd1;

            if (w_accept) begin
                r_instr_cnt   <= r_instr_cnt + 64'd1;
                r_expected_pc <= commit_pre_pc;
                r_timer       <= '0;
                r_state       <= (commit_instr == EBREAK_INSTR) ? S_HALT : S_RUN;
            end else if (w_live && commit) begin
                r_state    <= S_ERROR;
                r_err_code <= 2'd1;
                r_err_pc   <= commit_pc;
            end else if (r_state == S_RUN) begin
                if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_state    <= S_ERROR;
                    r_err_code <= 2'd2;
                    r_err_pc   <= r_expected_pc;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

    assign trace_valid = !w_empty;
    assign trace_pc    = w_empty ? 64'd0 : r_mem_pc[r_rd_ptr[AW-1:0]];
    assign trace_instr = w_empty ? 32'd0 : r_mem_instr[r_rd_ptr[AW-1:0]];
    assign instr_cnt   = r_instr_cnt;
    assign cycle_cnt   = r_cycle_cnt;
    assign running     = (r_state == S_RUN);
    assign halted      = (r_state == S_HALT);
    assign error       = (r_state == S_ERROR);
    assign err_code    = r_err_code;
    assign err_pc      = r_err_pc;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor with a 4-deep FIFO and an 8-cycle timeout.
module tb_commit_monitor;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [63:0] BASE   = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit = 1'b0;
    logic [31:0] commit_instr = '0;
    logic [63:0] commit_pc = '0;
    logic [63:0] commit_pre_pc = '0;
    logic        trace_ready = 1'b0;
    logic        trace_valid;
    logic [63:0] trace_pc;
    logic [31:0] trace_instr;
    logic [63:0] instr_cnt, cycle_cnt, err_pc;
    logic        running, halted, error, overflow;
    logic [1:0]  err_code;

    int n_pass = 0;
    int n_tot  = 0;

    commit_monitor #(
        .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8), .RESET_PC(64'h8000_0000), .EBREAK_INSTR(32'h0010_0073)
    ) dut (
        .clk(clk), .rst(rst), .commit(commit), .commit_instr(commit_instr),
        .commit_pc(commit_pc), .commit_pre_pc(commit_pre_pc),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_instr(trace_instr),
        .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt),
        .running(running), .halted(halted), .error(error),
        .err_code(err_code), .err_pc(err_pc), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; commit = 1'b0; trace_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic do_commit(input logic [63:0] pc, input logic [63:0] pre, input logic [31:0] ins);
        commit = 1'b1; commit_pc = pc; commit_pre_pc = pre; commit_instr = ins;
        tick();
        commit = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [63:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, 64'(trace_valid), 64'd1);
        chk({tag, "_pc"}, trace_pc, pc);
        chk({tag, "_instr"}, 64'(trace_instr), 64'(ins));
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_pc", trace_pc, 64'd0);
        chk("rst_icnt", instr_cnt, 64'd0);
        chk("rst_ccnt", cycle_cnt, 64'd0);
        chk("rst_status", {61'd0, running, halted, error}, 64'd0);
        chk("rst_errcode", 64'(err_code), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Sequential stream ending in ebreak
        for (int i = 0; i < 3; i++) do_commit(BASE + 64'(4*i), BASE + 64'(4*i + 4), NOP);
        chk("seq_running", 64'(running), 64'd1);
        do_commit(BASE + 64'hC, BASE + 64'h10, EBREAK);
        chk("seq_halted", 64'(halted), 64'd1);
        chk("seq_icnt", instr_cnt, 64'd4);
        chk("seq_ccnt", cycle_cnt, 64'd4);
        chk("seq_errcode", 64'(err_code), 64'd0);
        chk("seq_ovf", 64'(overflow), 64'd0);
        do_commit(BASE + 64'h10, BASE + 64'h14, NOP);
        tick();
        chk("halt_icnt_frozen", instr_cnt, 64'd4);
        chk("halt_ccnt_frozen", cycle_cnt, 64'd4);
        for (int i = 0; i < 3; i++) pop_check("seq_pop", BASE + 64'(4*i), NOP);
        pop_check("seq_pop_ebreak", BASE + 64'hC, EBREAK);
        chk("seq_empty", 64'(trace_valid), 64'd0);

        // Taken branch followed by a commit at the fall-through PC
        do_reset();
        trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) do_commit(BASE + 64'(4*i), BASE + 64'(4*i + 4), NOP);
        do_commit(BASE + 64'h10, BASE + 64'h100, NOP);
        chk("br_icnt_before", instr_cnt, 64'd5);
        do_commit(BASE + 64'h14, BASE + 64'h18, NOP);
        chk("br_error", 64'(error), 64'd1);
        chk("br_errcode", 64'(err_code), 64'd1);
        chk("br_errpc", err_pc, BASE + 64'h14);
        chk("br_icnt", instr_cnt, 64'd5);
        chk("br_ovf", 64'(overflow), 64'd0);
        trace_ready = 1'b0;

        // Wrong first PC
        do_reset();
        do_commit(64'h1000, 64'h1004, NOP);
        chk("first_error", 64'(error), 64'd1);
        chk("first_errcode", 64'(err_code), 64'd1);
        chk("first_errpc", err_pc, 64'h1000);
        chk("first_icnt", instr_cnt, 64'd0);
        chk("first_valid", 64'(trace_valid), 64'd0);

        // Timeout: 8 idle cycles after a commit
        do_reset();
        do_commit(BASE, BASE + 64'h40, NOP);
        for (int i = 0; i < 7; i++) tick();
        chk("to_not_yet", 64'(error), 64'd0);
        tick();
        chk("to_error", 64'(error), 64'd1);
        chk("to_errcode", 64'(err_code), 64'd2);
        chk("to_errpc", err_pc, BASE + 64'h40);
        chk("to_ccnt", cycle_cnt, 64'd9);

        // Overflow with reader stalled
        do_reset();
        chk("rst_after_err", {61'd0, running, halted, error}, 64'd0);
        for (int i = 0; i < 6; i++) do_commit(BASE + 64'(4*i), BASE + 64'(4*i + 4), 32'h1000_0000 + 32'(i));
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_icnt", instr_cnt, 64'd6);
        chk("ovf_running", 64'(running), 64'd1);
        for (int i = 0; i < 4; i++) pop_check("ovf_pop", BASE + 64'(4*i), 32'h1000_0000 + 32'(i));
        chk("ovf_empty", 64'(trace_valid), 64'd0);

        // Full FIFO with a pop in the same cycle as a push
        do_reset();
        for (int i = 0; i < 4; i++) do_commit(BASE + 64'(4*i), BASE + 64'(4*i + 4), NOP);
        chk("full_ovf_before", 64'(overflow), 64'd0);
        trace_ready = 1'b1;
        do_commit(BASE + 64'h10, BASE + 64'h14, 32'h0000_0093);
        trace_ready = 1'b0;
        chk("full_pop_ovf", 64'(overflow), 64'd0);
        chk("full_pop_icnt", instr_cnt, 64'd5);
        for (int i = 1; i < 4; i++) pop_check("full_pop", BASE + 64'(4*i), NOP);
        pop_check("full_pop_last", BASE + 64'h10, 32'h0000_0093);
        chk("full_empty", 64'(trace_valid), 64'd0);

        // Reset while records are queued discards them
        for (int i = 0; i < 2; i++) do_commit(BASE + 64'h14 + 64'(4*i), BASE + 64'h18 + 64'(4*i), NOP);
        chk("mid_valid", 64'(trace_valid), 64'd1);
        do_reset();
        chk("mid_rst_valid", 64'(trace_valid), 64'd0);
        chk("mid_rst_icnt", instr_cnt, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
